// File: rtl/ls_exec.sv
// Load/store execution unit: waits for RS operands, computes addr = datax + offset,
// runs byte-serial accesses on the memory port and broadcasts load results on the CDB.
module ls_exec #(
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int UNLOCKED = 0,
  parameter int RADDR_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               rs_busy,
  input  logic [5:0]         rs_op,
  input  logic [DATA_W-1:0]  rs_offset,
  input  logic [TAG_W-1:0]   rs_tagx,
  input  logic [TAG_W-1:0]   rs_tagy,
  input  logic [TAG_W-1:0]   rs_tagw,
  input  logic [DATA_W-1:0]  rs_datax,
  input  logic [DATA_W-1:0]  rs_datay,
  input  logic [RADDR_W-1:0] rs_target,
  output logic               ls_busy,
  output logic               mem_req,
  output logic               mem_we,
  output logic [31:0]        mem_addr,
  output logic [7:0]         mem_wdata,
  input  logic [7:0]         mem_rdata,
  input  logic               mem_ack,
  output logic               cdb_valid,
  output logic [TAG_W-1:0]   cdb_tag,
  output logic [RADDR_W-1:0] cdb_target,
  output logic [DATA_W-1:0]  cdb_data
);

  localparam logic [TAG_W-1:0] TAG_FREE = TAG_W'(UNLOCKED);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_load(input logic [2:0] op);
    is_load = (op <= 3'd4);
  endfunction

  // Index of the final byte of an access: byte ops 0, halfword 1, word 3.
  function automatic logic [1:0] last_idx(input logic [2:0] op);
    case (op)
      3'd0, 3'd3, 3'd5: last_idx = 2'd0;
      3'd1, 3'd4, 3'd6: last_idx = 2'd1;
      default:          last_idx = 2'd3;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [2:0] op, input logic [31:0] raw);
    case (op)
      3'd0:    extend = DATA_W'($signed(raw[7:0]));
      3'd1:    extend = DATA_W'($signed(raw[15:0]));
      3'd3:    extend = DATA_W'(raw[7:0]);
      3'd4:    extend = DATA_W'(raw[15:0]);
      default: extend = DATA_W'(raw);
    endcase
  endfunction

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [TAG_W-1:0]     tagw_q, tagw_d;
  logic [RADDR_W-1:0]   target_q, target_d;
  logic [31:0]          addr_q, addr_d;
  logic [DATA_W-1:0]    datay_q, datay_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [7:0]           mem_wdata_q, mem_wdata_d;
  logic                 cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]     cdb_tag_q, cdb_tag_d;
  logic [RADDR_W-1:0]   cdb_target_q, cdb_target_d;
  logic [DATA_W-1:0]    cdb_data_q, cdb_data_d;

  logic                 rs_load_s;
  logic                 rs_known_s;
  logic                 accept_s;
  logic [31:0]          rs_addr_s;
  logic                 last_s;
  logic [1:0]           cnt_nxt_s;
  logic [31:0]          raw_s;

  assign rs_load_s  = is_load(rs_op[2:0]);
  assign rs_known_s = (rs_op[5:3] == 3'd0);
  assign accept_s   = rs_busy && (rs_tagx == TAG_FREE) && (rs_load_s || (rs_tagy == TAG_FREE));
  assign rs_addr_s  = 32'(rs_datax + rs_offset);
  assign last_s     = (cnt_q == last_idx(op_q));
  assign cnt_nxt_s  = cnt_q + 2'd1;

  assign ls_busy    = rs_busy && (state_q != S_DONE);
  assign mem_req    = mem_req_q && rdy;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cdb_valid  = cdb_valid_q;
  assign cdb_tag    = cdb_tag_q;
  assign cdb_target = cdb_target_q;
  assign cdb_data   = cdb_data_q;

  // Load data gathered so far with the byte arriving this cycle merged in (little-endian).
  always_comb begin
    raw_s = rdata_q;
    raw_s[{cnt_q, 3'b000} +: 8] = mem_rdata;
  end

  // State and datapath registers; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= 3'd0;
      tagw_q       <= TAG_FREE;
      target_q     <= '0;
      addr_q       <= 32'd0;
      datay_q      <= '0;
      cnt_q        <= 2'd0;
      rdata_q      <= 32'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 8'd0;
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= TAG_FREE;
      cdb_target_q <= '0;
      cdb_data_q   <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      op_q         <= op_d;
      tagw_q       <= tagw_d;
      target_q     <= target_d;
      addr_q       <= addr_d;
      datay_q      <= datay_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_target_q <= cdb_target_d;
      cdb_data_q   <= cdb_data_d;
    end
  end

  // Next-state and latched-operand logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tagw_d   = tagw_q;
    target_d = target_q;
    addr_d   = addr_q;
    datay_d  = datay_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          op_d     = rs_op[2:0];
          tagw_d   = rs_tagw;
          target_d = rs_target;
          addr_d   = rs_addr_s;
          datay_d  = rs_datay;
          cnt_d    = 2'd0;
          rdata_d  = 32'd0;
          state_d  = rs_known_s ? S_MEM : S_DONE;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          rdata_d = is_load(op_q) ? raw_s : rdata_q;
          cnt_d   = cnt_nxt_s;
          state_d = last_s ? S_DONE : S_MEM;
        end else begin
          state_d = S_MEM;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered memory-port and CDB outputs for the next cycle.
  always_comb begin
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cdb_valid_d  = 1'b0;
    cdb_tag_d    = cdb_tag_q;
    cdb_target_d = cdb_target_q;
    cdb_data_d   = cdb_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && rs_known_s) begin
          mem_req_d   = 1'b1;
          mem_we_d    = !rs_load_s;
          mem_addr_d  = rs_addr_s;
          mem_wdata_d = rs_datay[7:0];
        end else if (accept_s) begin
          // Unrecognised op: retire with a zero result and no broadcast.
          cdb_tag_d    = TAG_FREE;
          cdb_target_d = rs_target;
          cdb_data_d   = '0;
        end else begin
          mem_req_d = 1'b0;
        end
      end
      S_MEM: begin
        if (mem_ack && last_s) begin
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          cdb_valid_d  = is_load(op_q) && (tagw_q != TAG_FREE);
          cdb_tag_d    = (is_load(op_q) && (tagw_q != TAG_FREE)) ? tagw_q : TAG_FREE;
          cdb_target_d = target_q;
          cdb_data_d   = is_load(op_q) ? extend(op_q, raw_s) : '0;
        end else if (mem_ack) begin
          mem_addr_d  = addr_q + {30'd0, cnt_nxt_s};
          mem_wdata_d = datay_q[{cnt_nxt_s, 3'b000} +: 8];
        end else begin
          mem_req_d = 1'b1;
        end
      end
      S_DONE:  mem_req_d = 1'b0;
      default: mem_req_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ls_exec.sv
// Directed bench for ls_exec: a table of single load/store transactions plus
// hand-written sequences for operand waits, stalls, rdy freeze, unknown op and reset.
module tb_ls_exec;

  logic        clk = 1'b0;
  logic        rst, rdy, rs_busy;
  logic [5:0]  rs_op;
  logic [31:0] rs_offset, rs_datax, rs_datay;
  logic [3:0]  rs_tagx, rs_tagy, rs_tagw;
  logic [4:0]  rs_target;
  logic        ls_busy, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [4:0]  cdb_target;
  logic [31:0] cdb_data;

  int n_checks = 0;
  int n_fail   = 0;

  ls_exec #(.DATA_W(32), .TAG_W(4), .UNLOCKED(0), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rs_busy(rs_busy), .rs_op(rs_op),
    .rs_offset(rs_offset), .rs_tagx(rs_tagx), .rs_tagy(rs_tagy), .rs_tagw(rs_tagw),
    .rs_datax(rs_datax), .rs_datay(rs_datay), .rs_target(rs_target),
    .ls_busy(ls_busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_target(cdb_target), .cdb_data(cdb_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no $finish, required $finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0]  op;
    logic [31:0] datax;
    logic [31:0] offset;
    logic [31:0] datay;
    logic [3:0]  tagw;
    int          nbytes;
    logic [31:0] rd;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] dx, input logic [31:0] off,
                       input logic [31:0] dy, input logic [3:0] tx, input logic [3:0] ty,
                       input logic [3:0] tw, input logic [4:0] tgt);
    @(posedge clk); #1;
    rs_busy = 1'b1; rs_op = op; rs_datax = dx; rs_offset = off; rs_datay = dy;
    rs_tagx = tx; rs_tagy = ty; rs_tagw = tw; rs_target = tgt;
  endtask

  // Serve bytes first..first+n-1: wait (bounded) for a request, check it, ack it.
  task automatic serve(input int first, input int n, input logic [31:0] base,
                       input logic [31:0] rd, input logic [31:0] wd, input logic we,
                       output int waits);
    int w;
    logic [31:0] a;
    waits = 0;
    for (int i = first; i < first + n; i++) begin
      w = 0;
      @(negedge clk);
      while (!mem_req && w < 20) begin
        @(negedge clk);
        w++;
      end
      waits += w;
      a = base + 32'(i);
      chk("mem_req_seen", {31'd0, mem_req}, 32'd1);
      chk("mem_addr", mem_addr, a);
      chk("mem_we", {31'd0, mem_we}, {31'd0, we});
      if (we) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, wd[8*i +: 8]});
      mem_rdata = rd[8*i +: 8];
      mem_ack   = 1'b1;
      @(posedge clk); #1;
      mem_ack   = 1'b0;
    end
  endtask

  task automatic finish_done(input logic exp_valid, input logic [31:0] exp_data,
                             input logic [3:0] tw, input logic [4:0] tgt);
    @(negedge clk);
    chk("done_cdb_valid", {31'd0, cdb_valid}, {31'd0, exp_valid});
    chk("done_ls_busy", {31'd0, ls_busy}, 32'd0);
    chk("done_mem_req", {31'd0, mem_req}, 32'd0);
    if (exp_valid) begin
      chk("cdb_data", cdb_data, exp_data);
      chk("cdb_tag", {28'd0, cdb_tag}, {28'd0, tw});
      chk("cdb_target", {27'd0, cdb_target}, {27'd0, tgt});
    end
    @(posedge clk); #1;
    rs_busy = 1'b0;
    @(negedge clk);
    chk("cdb_pulse_end", {31'd0, cdb_valid}, 32'd0);
  endtask

  initial begin
    int waits;
    //                op      datax         offset        datay         tw     n  rd            addr          we    val   data
    vecs[0]  = '{6'd2, 32'h0000_0100, 32'h0000_0000, 32'h0,        4'd5,  4, 32'h1234_5678, 32'h0000_0100, 1'b0, 1'b1, 32'h1234_5678};
    vecs[1]  = '{6'd0, 32'h0000_0010, 32'h0000_0010, 32'h0,        4'd6,  1, 32'h0000_0080, 32'h0000_0020, 1'b0, 1'b1, 32'hFFFF_FF80};
    vecs[2]  = '{6'd3, 32'h0000_0010, 32'h0000_0010, 32'h0,        4'd7,  1, 32'h0000_0080, 32'h0000_0020, 1'b0, 1'b1, 32'h0000_0080};
    vecs[3]  = '{6'd1, 32'h0000_0040, 32'h0000_0000, 32'h0,        4'd8,  2, 32'h0000_9234, 32'h0000_0040, 1'b0, 1'b1, 32'hFFFF_9234};
    vecs[4]  = '{6'd4, 32'h0000_0040, 32'h0000_0000, 32'h0,        4'd8,  2, 32'h0000_9234, 32'h0000_0040, 1'b0, 1'b1, 32'h0000_9234};
    vecs[5]  = '{6'd6, 32'h0000_0200, 32'h0000_0003, 32'h0000_ABCD, 4'd9, 2, 32'h0,         32'h0000_0203, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{6'd7, 32'hFFFF_FFFE, 32'h0000_0000, 32'hDEAD_BEEF, 4'd10, 4, 32'h0,        32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{6'd2, 32'h0000_0300, 32'h0000_0004, 32'h0,        4'd0,  4, 32'hCAFE_F00D, 32'h0000_0304, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{6'd5, 32'h0000_0010, 32'hFFFF_FFFF, 32'h1234_5677, 4'd11, 1, 32'h0,        32'h0000_000F, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{6'd2, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0,        4'd12, 4, 32'h8003_0201, 32'h0000_0FFC, 1'b0, 1'b1, 32'h8003_0201};
    vecs[10] = '{6'd0, 32'h0000_0000, 32'h0000_0055, 32'h0,        4'd13, 1, 32'h0000_007F, 32'h0000_0055, 1'b0, 1'b1, 32'h0000_007F};

    rst = 1'b1; rdy = 1'b1; rs_busy = 1'b0; rs_op = 6'd0; rs_offset = 32'd0;
    rs_datax = 32'd0; rs_datay = 32'd0; rs_tagx = 4'd0; rs_tagy = 4'd0; rs_tagw = 4'd0;
    rs_target = 5'd0; mem_ack = 1'b0; mem_rdata = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_cdb_valid", {31'd0, cdb_valid}, 32'd0);
    chk("rst_cdb_tag", {28'd0, cdb_tag}, 32'd0);
    chk("rst_cdb_target", {27'd0, cdb_target}, 32'd0);
    chk("rst_cdb_data", cdb_data, 32'd0);
    chk("rst_ls_busy", {31'd0, ls_busy}, 32'd0);

    // Table: loads carry a locked tagy, which must not delay them.
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].op, vecs[i].datax, vecs[i].offset, vecs[i].datay, 4'd0,
            vecs[i].exp_we ? 4'd0 : 4'd15, vecs[i].tagw, 5'(i + 1));
      serve(0, vecs[i].nbytes, vecs[i].exp_addr, vecs[i].rd, vecs[i].datay, vecs[i].exp_we, waits);
      chk("accept_latency", 32'(waits), 32'd1);
      finish_done(vecs[i].exp_valid, vecs[i].exp_data, vecs[i].tagw, 5'(i + 1));
    end

    // Base tag locked for 5 cycles: request only the cycle after unlock.
    issue(6'd2, 32'h0000_0100, 32'h0, 32'h0, 4'd3, 4'd0, 4'd4, 5'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("tagx_wait_req", {31'd0, mem_req}, 32'd0);
    end
    @(posedge clk); #1;
    rs_tagx = 4'd0;
    serve(0, 4, 32'h0000_0100, 32'h1234_5678, 32'h0, 1'b0, waits);
    chk("tagx_unlock_latency", 32'(waits), 32'd1);
    finish_done(1'b1, 32'h1234_5678, 4'd4, 5'd3);

    // Store with store-data tag locked also waits.
    issue(6'd7, 32'h0000_0400, 32'h0, 32'h0102_0304, 4'd0, 4'd2, 4'd5, 5'd4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("tagy_wait_req", {31'd0, mem_req}, 32'd0);
    end
    @(posedge clk); #1;
    rs_tagy = 4'd0;
    serve(0, 4, 32'h0000_0400, 32'h0, 32'h0102_0304, 1'b1, waits);
    chk("tagy_unlock_latency", 32'(waits), 32'd1);
    finish_done(1'b0, 32'h0, 4'd5, 5'd4);

    // LW with ack stall, rdy freeze and RS operands changing after accept.
    issue(6'd2, 32'h0000_0100, 32'h0, 32'h0, 4'd0, 4'd0, 4'd6, 5'd9);
    serve(0, 1, 32'h0000_0100, 32'h1234_5678, 32'h0, 1'b0, waits);
    rs_datax = 32'hDEAD_0000; rs_op = 6'd7; rs_tagw = 4'd1; rs_target = 5'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_req", {31'd0, mem_req}, 32'd1);
      chk("stall_addr", mem_addr, 32'h0000_0101);
    end
    @(posedge clk); #1;
    rdy = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hEE;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rdy_low_req", {31'd0, mem_req}, 32'd0);
      chk("rdy_low_addr", mem_addr, 32'h0000_0101);
      if (k == 0) @(posedge clk);
    end
    @(posedge clk); #1;
    rdy = 1'b1; mem_ack = 1'b0;
    serve(1, 3, 32'h0000_0100, 32'h1234_5678, 32'h0, 1'b0, waits);
    finish_done(1'b1, 32'h1234_5678, 4'd6, 5'd9);

    // High op bits set: retire without any memory access, zero data.
    issue(6'b001010, 32'h0000_0100, 32'h0, 32'h0, 4'd0, 4'd0, 4'd4, 5'd2);
    @(negedge clk);
    chk("unk_idle_busy", {31'd0, ls_busy}, 32'd1);
    @(negedge clk);
    chk("unk_done_busy", {31'd0, ls_busy}, 32'd0);
    chk("unk_mem_req", {31'd0, mem_req}, 32'd0);
    chk("unk_cdb_data", cdb_data, 32'd0);
    @(posedge clk); #1;
    rs_busy = 1'b0;

    // Reset after 2 of 4 LW bytes aborts the access.
    issue(6'd2, 32'h0000_0100, 32'h0, 32'h0, 4'd0, 4'd0, 4'd7, 5'd5);
    serve(0, 2, 32'h0000_0100, 32'h1234_5678, 32'h0, 1'b0, waits);
    rst = 1'b1; rs_busy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_cdb_tag", {28'd0, cdb_tag}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      mem_ack = 1'b1;
      @(negedge clk);
      chk("abort_no_cdb", {31'd0, cdb_valid}, 32'd0);
      chk("abort_no_req", {31'd0, mem_req}, 32'd0);
    end
    mem_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
